// File: rtl/gf2_poly_divider_if.sv
// Handshake and operand/result bundle for the bit-serial GF(2) polynomial divider.
interface gf2_poly_divider_if #(
    parameter int unsigned N  = 233,
    parameter int unsigned DW = 2 * N
);
    logic          start;
    logic [DW-1:0] dividend;
    logic [N-1:0]  divisor;
    logic          busy;
    logic          done;
    logic          err;
    logic [DW-1:0] quotient;
    logic [N-1:0]  remainder;

    modport master (
        output start, dividend, divisor,
        input  busy, done, err, quotient, remainder
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, err, quotient, remainder
    );
endinterface

// File: rtl/gf2_poly_divider.sv
// Bit-serial GF(2)[x] long divider: one dividend bit per cycle, MSB first.
// Produces quotient/remainder with a start/busy/done handshake; zero divisor flags err.
module gf2_poly_divider #(
    parameter int unsigned N  = 233,
    parameter int unsigned DW = 2 * N
) (
    input logic               clk,
    input logic               rst,
    gf2_poly_divider_if.slave bus
);
    localparam int unsigned IW = $clog2(N);
    localparam int unsigned CW = $clog2(DW);

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state_q, state_nxt;
    logic [DW-1:0]  dvd_q, dvd_nxt;
    logic [N-1:0]   dvs_q, dvs_nxt;
    logic [IW-1:0]  d_q, d_nxt;
    logic [N-2:0]   r_q, r_nxt;
    logic [CW-1:0]  cnt_q, cnt_nxt;
    logic           busy_q, busy_nxt;
    logic           done_q, done_nxt;
    logic           err_q, err_nxt;
    logic [DW-1:0]  quot_q, quot_nxt;
    logic [N-1:0]   rem_q, rem_nxt;

    logic [IW-1:0]  lod;
    logic [N-1:0]   shifted;
    logic           qbit;
    logic [N-1:0]   r_step;

    // Leading-one detect on the incoming divisor (index of its highest set bit).
    always_comb begin
        lod = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.divisor[i]) lod = IW'(i);
        end
    end

    // deg(R) < d <= N-1, so R fits in N-1 bits and the reduced step never sets bit N-1.
    assign shifted = {r_q, dvd_q[DW-1]};
    assign qbit    = shifted[d_q];
    assign r_step  = qbit ? (shifted ^ dvs_q) : shifted;

    // Quotient bits shift into the bottom of the dividend register as dividend bits leave the top.
    always_comb begin
        state_nxt = state_q;
        dvd_nxt   = dvd_q;
        dvs_nxt   = dvs_q;
        d_nxt     = d_q;
        r_nxt     = r_q;
        cnt_nxt   = cnt_q;
        busy_nxt  = busy_q;
        done_nxt  = 1'b0;
        err_nxt   = err_q;
        quot_nxt  = quot_q;
        rem_nxt   = rem_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    dvd_nxt = bus.dividend;
                    dvs_nxt = bus.divisor;
                    d_nxt   = lod;
                    r_nxt   = '0;
                    cnt_nxt = CW'(DW - 1);
                    err_nxt = 1'b0;
                    if (bus.divisor == '0) begin
                        done_nxt = 1'b1;
                        err_nxt  = 1'b1;
                        quot_nxt = '0;
                        rem_nxt  = '0;
                    end else begin
                        busy_nxt  = 1'b1;
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                dvd_nxt = {dvd_q[DW-2:0], qbit};
                r_nxt   = r_step[N-2:0];
                if (cnt_q == '0) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    quot_nxt  = {dvd_q[DW-2:0], qbit};
                    rem_nxt   = r_step;
                end else begin
                    cnt_nxt = cnt_q - CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            d_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_nxt;
            dvd_q   <= dvd_nxt;
            dvs_q   <= dvs_nxt;
            d_q     <= d_nxt;
            r_q     <= r_nxt;
            cnt_q   <= cnt_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
            err_q   <= err_nxt;
            quot_q  <= quot_nxt;
            rem_q   <= rem_nxt;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.quotient  = quot_q;
    assign bus.remainder = rem_q;
endmodule

// File: tb/tb_gf2_poly_divider.sv
// Scoreboard bench for gf2_poly_divider: directed vectors, queue of expected results, negedge monitor.
module tb_gf2_poly_divider;
    localparam int unsigned N  = 233;
    localparam int unsigned DW = 2 * N;

    typedef struct {
        string         name;
        logic [DW-1:0] q;
        logic [N-1:0]  r;
        logic          e;
        int            due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t mon_e;

    gf2_poly_divider_if #(.N(N), .DW(DW)) bus ();

    gf2_poly_divider #(.N(N), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] clmul(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [DW-1:0] p;
        p = '0;
        for (int i = 0; i < N; i++) begin
            if (b[i]) p = p ^ (DW'(a) << i);
        end
        return p;
    endfunction

    // Monitor: compare every done pulse against the oldest expected result.
    always @(negedge clk) begin
        if (!rst) begin
            if (sb.size() > 0 && sb[0].due < cyc) begin
                mon_e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL %s timeout: no done at cycle %0d (now %0d)", mon_e.name, mon_e.due, cyc);
            end
            if (bus.done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected done at cycle %0d", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk_int({mon_e.name, " latency"}, cyc, mon_e.due);
                    chk({mon_e.name, " quotient"}, bus.quotient, mon_e.q);
                    chk({mon_e.name, " remainder"}, DW'(bus.remainder), DW'(mon_e.r));
                    chk({mon_e.name, " err"}, DW'(bus.err), DW'(mon_e.e));
                end
            end
        end
    end

    // Called at a negedge; drives one request across the next rising edge.
    task automatic issue_now(input string name, input logic [DW-1:0] dvd, input logic [N-1:0] dvs,
                             input logic [DW-1:0] q, input logic [N-1:0] r, input logic e, input bit push);
        exp_t x;
        bus.start    = 1'b1;
        bus.dividend = dvd;
        bus.divisor  = dvs;
        if (push) begin
            x.name = name;
            x.q    = q;
            x.r    = r;
            x.e    = e;
            x.due  = cyc + 1 + ((dvs == '0) ? 0 : int'(DW));
            sb.push_back(x);
        end
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = '1;
        bus.divisor  = '1;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (bus.busy && n < 3 * int'(DW)) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) chk_int("wait_idle busy stuck", 1, 0);
    endtask

    task automatic issue(input string name, input logic [DW-1:0] dvd, input logic [N-1:0] dvs,
                         input logic [DW-1:0] q, input logic [N-1:0] r, input logic e);
        wait_idle();
        issue_now(name, dvd, dvs, q, r, e, 1'b1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() > 0 && n < 4 * int'(DW)) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) chk_int("drain pending results", sb.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0]  a_w, b_w, r0_w;
        logic [DW-1:0] g;
        int            bc;

        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset busy", DW'(bus.busy), '0);
        chk("reset done", DW'(bus.done), '0);
        chk("reset err", DW'(bus.err), '0);
        chk("reset quotient", bus.quotient, '0);
        chk("reset remainder", DW'(bus.remainder), '0);
        rst = 1'b0;

        // T1 plus busy-duration check
        issue("t1", DW'(4'hF), N'(2'h3), DW'(4'h5), '0, 1'b0);
        bc = 0;
        @(negedge clk);
        while (bus.busy && bc < 2 * int'(DW)) begin
            bc++;
            @(negedge clk);
        end
        chk_int("t1 busy cycles", bc, int'(DW));

        issue("t2", DW'(5'h1F), N'(2'h3), DW'(4'hA), N'(1'b1), 1'b0);
        issue("div_by_x", DW'(3'h7), N'(2'h2), DW'(2'h3), N'(1'b1), 1'b0);
        issue("x4_mod_7", DW'(5'h10), N'(3'h7), DW'(3'h6), N'(2'h2), 1'b0);
        issue("zero_dividend", '0, N'(3'h5), '0, '0, 1'b0);
        issue("small_dividend", DW'(3'h5), N'(5'h1F), '0, N'(3'h5), 1'b0);

        // Wide cases: dividend built as a*b ^ r0 with deg(r0) < deg(b)
        a_w  = N'({8{32'hDEADBEEF}});
        b_w  = (N'(1) << (N - 1)) | (N'(1) << 74) | N'(1);
        r0_w = N'({8{32'h13579BDF}}) & ~(N'(1) << (N - 1));
        issue("wide_top_deg", clmul(a_w, b_w) ^ DW'(r0_w), b_w, DW'(a_w), r0_w, 1'b0);
        a_w  = N'({8{32'h8C4A_F135}});
        b_w  = N'(8'h8D);
        r0_w = N'(7'h5A);
        issue("wide_deg7", clmul(a_w, b_w) ^ DW'(r0_w), b_w, DW'(a_w), r0_w, 1'b0);
        issue("divisor_one", '1, N'(1'b1), '1, '0, 1'b0);

        // T4: zero divisor, err held, then cleared by the next valid start
        issue("t4_zero_div", DW'(12'hABC), '0, '0, '0, 1'b1);
        wait_drain();
        repeat (3) @(negedge clk);
        chk("t4 err held", DW'(bus.err), DW'(1'b1));
        chk("t4 quotient held", bus.quotient, '0);
        issue("t4_recover", DW'(4'hF), N'(2'h3), DW'(4'h5), '0, 1'b0);

        // T5: start held with junk operands during RUN, then back-to-back in the done cycle
        wait_idle();
        issue_now("t5_first", DW'(5'h10), N'(3'h7), DW'(3'h6), N'(2'h2), 1'b0, 1'b1);
        for (int i = 0; i < 2 * int'(DW); i++) begin
            @(negedge clk);
            if (!bus.busy) break;
            for (int w = 0; w < int'(DW); w++) g[w] = 1'($urandom_range(0, 1));
            bus.start    = 1'b1;
            bus.dividend = g;
            bus.divisor  = N'(g);
            if (i == 50) begin
                chk("t5 quotient stable in run", bus.quotient, DW'(4'h5));
                chk("t5 remainder stable in run", DW'(bus.remainder), '0);
            end
        end
        issue_now("t5_second", DW'(5'h1F), N'(2'h3), DW'(4'hA), N'(1'b1), 1'b0, 1'b1);
        wait_drain();

        // T6: asynchronous reset mid-run, then a clean T1
        wait_idle();
        issue_now("t6_killed", DW'(4'hF), N'(2'h3), '0, '0, 1'b0, 1'b0);
        repeat (100) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t6 busy after rst", DW'(bus.busy), '0);
        chk("t6 done after rst", DW'(bus.done), '0);
        chk("t6 err after rst", DW'(bus.err), '0);
        chk("t6 quotient after rst", bus.quotient, '0);
        chk("t6 remainder after rst", DW'(bus.remainder), '0);
        @(negedge clk);
        rst = 1'b0;
        issue("t6_after_rst", DW'(4'hF), N'(2'h3), DW'(4'h5), '0, 1'b0);
        wait_drain();
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
